spmv_csr_feeder: RTL
====================

// Module: spmv_csr_feeder
// PURPOSE
//  Initiator side of the SpMV_core operand interface: walks a CSR matrix held in on-chip SRAMs
//  (values, column indices, dense vector x) and streams one nonzero per beat to SpMV_core as
//  (A=val[k], B=x[col[k]], count=k), with a stable row_ptr. Replaces bench-driven stimulus.
//  Waits for core done, captures the result vector and hands it to the host.
// PARAMETERS
//  DATA_W      16   operand width (fp16, passed through untouched)
//  IDX_W       8    nonzero index / column index / SRAM address width
//  ROWS        16   matrix rows; row_ptr has ROWS+1 entries of IDX_W bits
//  BEAT_CYCLES 4    cycles each nonzero is held on the core interface; legal range >= 3
// PORTS
//  i_clk           in   1                  clock, rising edge
//  i_rstn          in   1                  async active-low reset
//  i_start         in   1                  host start pulse, sampled in IDLE only
//  i_row_ptr       in   (ROWS+1)*IDX_W     CSR row pointers; top entry = nnz
//  o_busy          out  1                  high from accepted start to o_done
//  o_done          out  1                  1-cycle pulse, result valid
//  o_result        out  ROWS*DATA_W        captured core result, held until next done
//  o_nz_rd         out  1                  read enable, value+column SRAMs (shared addr)
//  o_nz_addr       out  IDX_W              nonzero index k
//  i_val_rdata     in   DATA_W             val[k], valid 1 cycle after o_nz_rd
//  i_col_rdata     in   IDX_W              col[k], valid 1 cycle after o_nz_rd
//  o_x_rd          out  1                  read enable, x SRAM
//  o_x_addr        out  IDX_W              column index
//  i_x_rdata       in   DATA_W             x[col], valid 1 cycle after o_x_rd
//  o_core_start    out  1                  to core i_start
//  o_read_data_A   out  DATA_W             to core i_read_data_A
//  o_read_data_B   out  DATA_W             to core i_read_data_B
//  o_count         out  IDX_W              to core count
//  o_row_ptr       out  (ROWS+1)*IDX_W     to core row_ptr
//  i_core_done     in   1                  from core o_done
//  i_core_register in   ROWS*DATA_W        from core o_register
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shadow/beat/index registers 0. Reset mid-run aborts
//   immediately; no o_done is issued for the aborted run.
//  IDLE: i_start=1 -> latch o_row_ptr<=i_row_ptr, nnz<=top entry, k<=0, o_busy<=1.
//   nnz==0 -> go DONE (no SRAM reads, o_core_start never rises). Else go PRIME.
//  PRIME (3 cycles, fetches element 0): p0 o_nz_rd=1, addr 0; p1 o_x_rd=1, addr=i_col_rdata,
//   val captured; p2 capture i_x_rdata; on edge leaving p2 load A=val, B=x, o_count=0,
//   o_core_start<=1; go RUN with beat b=0. First beat visible 4 cycles after start edge.
//  RUN: each beat lasts exactly BEAT_CYCLES cycles; A/B/count change only at beat boundaries.
//   Prefetch of k+1 overlaps beat k when k+1<nnz: b=0 o_nz_rd, addr k+1; b=1 o_x_rd,
//   addr=col; b=2 shadow<=i_x_rdata (val shadowed at b=1). At b=BEAT_CYCLES-1:
//   k+1<nnz -> A,B<=shadow, o_count<=k+1, k<=k+1, b<=0; else -> WAIT.
//  WAIT: o_core_start<=0; A,B,o_count hold last beat. i_core_done=1 -> o_result<=
//   i_core_register, go DONE.
//  DONE: o_done=1 one cycle, o_busy<=0, go IDLE. nnz==0 path: o_result<=0.
//  i_start outside IDLE ignored; accepted in IDLE only, so a start coincident with o_done is
//   dropped (earliest restart = cycle after o_done). i_core_done outside WAIT ignored.
//  SRAM enables asserted only in the listed cycles (no reads for k>=nnz). Index k, nnz and
//   o_count are IDX_W-bit, nnz max 2^IDX_W-1; no wrap occurs. No arithmetic on data.
// TESTING
//  T1 row_ptr=0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00, val[0]=0x4C00, x[col0]=0x4000,
//     val[1]=0x4200, x[col1]=0x4700 -> beats (A,B,count) (4C00,4000,0),(4200,4700,1)...,
//     count 0..9 each held 4 cycles, o_core_start high 40 cycles.
//  T2 core model returns 0x5000 per row after 2-cycle delay -> o_done 1 cycle, o_result captured,
//     o_busy 0.
//  T3 nnz=0 -> no SRAM reads, o_core_start stays 0, o_done 2 cycles after start, o_result=0.
//  T4 BEAT_CYCLES=3, nnz=5 -> counts 0..4, each exactly 3 cycles, no bubble.
//  T5 i_rstn low during beat count=3 -> all outputs 0 at once; fresh start runs cleanly.
//  T6 i_start during RUN and on o_done cycle -> ignored; spurious i_core_done in RUN ignored.

Source files
------------

// File: rtl/spmv_csr_feeder.sv
// CSR walker feeding SpMV_core: streams (val[k], x[col[k]], k) one nonzero per beat,
// prefetching k+1 under beat k, then captures the core result for the host.
module spmv_csr_feeder #(
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 8,
    parameter int ROWS        = 16,
    parameter int BEAT_CYCLES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_start,
    input  logic [(ROWS+1)*IDX_W-1:0] i_row_ptr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [ROWS*DATA_W-1:0]    o_result,
    output logic                      o_nz_rd,
    output logic [IDX_W-1:0]          o_nz_addr,
    input  logic [DATA_W-1:0]         i_val_rdata,
    input  logic [IDX_W-1:0]          i_col_rdata,
    output logic                      o_x_rd,
    output logic [IDX_W-1:0]          o_x_addr,
    input  logic [DATA_W-1:0]         i_x_rdata,
    output logic                      o_core_start,
    output logic [DATA_W-1:0]         o_read_data_A,
    output logic [DATA_W-1:0]         o_read_data_B,
    output logic [IDX_W-1:0]          o_count,
    output logic [(ROWS+1)*IDX_W-1:0] o_row_ptr,
    input  logic                      i_core_done,
    input  logic [ROWS*DATA_W-1:0]    i_core_register
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BW-1:0]    B_ONE  = BW'(1);
    localparam logic [BW-1:0]    B_TWO  = BW'(2);
    localparam logic [BW-1:0]    B_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [IDX_W-1:0] K_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [IDX_W-1:0]  cnt;
    } beat_t;

    logic [2:0]                r_state;
    logic [1:0]                r_ph;
    logic [BW-1:0]             r_beat;
    logic [IDX_W-1:0]          r_k;
    logic [IDX_W-1:0]          r_nnz;
    logic [DATA_W-1:0]         r_sh_val;
    logic [DATA_W-1:0]         r_sh_x;
    beat_t                     r_out;
    logic                      r_core_start;
    logic                      r_busy;
    logic                      r_done;
    logic [ROWS*DATA_W-1:0]    r_result;
    logic [(ROWS+1)*IDX_W-1:0] r_row_ptr;

    logic [IDX_W-1:0]  w_top;
    logic [IDX_W-1:0]  w_k_nxt;
    logic              w_more;
    logic              w_nz_rd;
    logic              w_x_rd;
    logic [IDX_W-1:0]  w_nz_addr;
    logic [DATA_W-1:0] w_x_next;

    assign w_top   = i_row_ptr[ROWS*IDX_W +: IDX_W];
    assign w_k_nxt = r_k + K_ONE;
    assign w_more  = ({1'b0, r_k} + {1'b0, K_ONE}) < {1'b0, r_nnz};
    // With a 3-cycle beat the x word lands on the same edge that swaps the beat.
    assign w_x_next = (r_beat == B_TWO) ? i_x_rdata : r_sh_x;

    always_comb begin
        w_nz_rd   = 1'b0;
        w_x_rd    = 1'b0;
        w_nz_addr = '0;
        if (r_state == S_PRIME) begin
            w_nz_rd = (r_ph == 2'd0);
            w_x_rd  = (r_ph == 2'd1);
        end else if (r_state == S_RUN && w_more) begin
            w_nz_rd   = (r_beat == '0);
            w_x_rd    = (r_beat == B_ONE);
            w_nz_addr = w_k_nxt;
        end
    end

    assign o_nz_rd   = w_nz_rd;
    assign o_nz_addr = w_nz_rd ? w_nz_addr : '0;
    assign o_x_rd    = w_x_rd;
    assign o_x_addr  = w_x_rd ? i_col_rdata : '0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_ph         <= '0;
            r_beat       <= '0;
            r_k          <= '0;
            r_nnz        <= '0;
            r_sh_val     <= '0;
            r_sh_x       <= '0;
            r_out        <= '0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= '0;
            r_row_ptr    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // r_done still high here means this is the o_done cycle: drop the start.
                    if (i_start && !r_done) begin
                        r_row_ptr <= i_row_ptr;
                        r_nnz     <= w_top;
                        r_k       <= '0;
                        r_ph      <= '0;
                        r_beat    <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= (w_top == '0) ? S_DONE : S_PRIME;
                    end
                end
                S_PRIME: begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == 2'd1)
                        r_sh_val <= i_val_rdata;
                    if (r_ph == 2'd2) begin
                        r_out.a      <= r_sh_val;
                        r_out.b      <= i_x_rdata;
                        r_out.cnt    <= '0;
                        r_core_start <= 1'b1;
                        r_beat       <= '0;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_more && r_beat == B_ONE)
                        r_sh_val <= i_val_rdata;
                    if (w_more && r_beat == B_TWO)
                        r_sh_x <= i_x_rdata;
                    if (r_beat == B_LAST) begin
                        r_beat <= '0;
                        if (w_more) begin
                            r_out.a   <= r_sh_val;
                            r_out.b   <= w_x_next;
                            r_out.cnt <= w_k_nxt;
                            r_k       <= w_k_nxt;
                        end else begin
                            r_core_start <= 1'b0;
                            r_state      <= S_WAIT;
                        end
                    end else begin
                        r_beat <= r_beat + B_ONE;
                    end
                end
                S_WAIT: begin
                    r_core_start <= 1'b0;
                    if (i_core_done) begin
                        r_result <= i_core_register;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    if (r_nnz == '0)
                        r_result <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_core_start  = r_core_start;
    assign o_read_data_A = r_out.a;
    assign o_read_data_B = r_out.b;
    assign o_count       = r_out.cnt;
    assign o_row_ptr     = r_row_ptr;

endmodule
